// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage: valid/ready in, valid/ready out,
// one-cycle latency, a second (skid) entry to keep full rate under back-pressure, and a sync flush.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_imm_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [XLEN-1:0]  r_main_imm;
    logic [XLEN-1:0]  w_main_imm_next;
    logic [TAG_W-1:0] r_main_tag;
    logic [TAG_W-1:0] w_main_tag_next;
    logic [XLEN-1:0]  r_skid_imm;
    logic [XLEN-1:0]  w_skid_imm_next;
    logic [TAG_W-1:0] r_skid_tag;
    logic [TAG_W-1:0] w_skid_tag_next;
    logic [XLEN-1:0]  w_imm;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_unused_opcode;

    // The opcode field never contributes to an immediate.
    assign w_unused_opcode = ^in_inst[6:0];

    // Size casts of $signed operands sign-extend to XLEN.
    always_comb begin
        w_imm = '0;
        case (in_imm_type)
            3'd1:    w_imm = XLEN'($signed(in_inst[31:20]));
            3'd2:    w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            3'd3:    w_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                            in_inst[11:8], 1'b0}));
            3'd4:    w_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            3'd5:    w_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                            in_inst[30:21], 1'b0}));
            3'd6:    w_imm = XLEN'(in_inst[19:15]);
            3'd7:    w_imm = (XLEN == 64) ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
            default: w_imm = '0;
        endcase
    end

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    always_comb begin
        w_state_next    = r_state;
        w_main_imm_next = r_main_imm;
        w_main_tag_next = r_main_tag;
        w_skid_imm_next = r_skid_imm;
        w_skid_tag_next = r_skid_tag;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_main_imm_next = w_imm;
                        w_main_tag_next = in_tag;
                        w_state_next    = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_imm_next = w_imm;
                        w_main_tag_next = in_tag;
                    end else if (w_in_xfer) begin
                        w_skid_imm_next = w_imm;
                        w_skid_tag_next = in_tag;
                        w_state_next    = ST_FULL;
                    end else if (w_out_xfer) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        w_main_imm_next = r_skid_imm;
                        w_main_tag_next = r_skid_tag;
                        w_state_next    = ST_BUSY;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered copies of the next state so in_ready never sees out_ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_imm  <= '0;
            r_main_tag  <= '0;
            r_skid_imm  <= '0;
            r_skid_tag  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next != ST_EMPTY);
            r_in_ready  <= (w_state_next != ST_FULL);
            r_main_imm  <= w_main_imm_next;
            r_main_tag  <= w_main_tag_next;
            r_skid_imm  <= w_skid_imm_next;
            r_skid_tag  <= w_skid_tag_next;
        end
    end

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign out_imm   = r_main_imm;
    assign out_tag   = r_main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit instance for streaming scenarios and a 64-bit
// instance for the wide-extension cases.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [2:0]  in_imm_type;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_tag;

    logic        flush64;
    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_inst64;
    logic [2:0]  in_imm_type64;
    logic [31:0] in_tag64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] tag;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    verbose  = 1'b1;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rstn(rstn), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst64),
        .in_imm_type(in_imm_type64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64), .out_tag(out_tag64)
    );

    // Reference immediate: place the field at the top of a 32-bit word, then arithmetic-shift down.
    function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] t, input int xlen);
        logic signed [31:0] s;
        longint             v;
        v = 0;
        case (t)
            3'd1: begin s = {inst[31:20], 20'b0}; v = longint'(s) >>> 20; end
            3'd2: begin s = {inst[31:25], inst[11:7], 20'b0}; v = longint'(s) >>> 20; end
            3'd3: begin s = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0, 19'b0}; v = longint'(s) >>> 19; end
            3'd4: begin s = {inst[31:12], 12'b0}; v = longint'(s); end
            3'd5: begin s = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0, 11'b0}; v = longint'(s) >>> 11; end
            3'd6: v = longint'(inst[19:15]);
            3'd7: v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return 64'(v);
    endfunction

    // Output side of the scoreboard: every delivered entry is popped and compared.
    always @(negedge clk) begin
        item_t e;
        if (rstn && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL out_unexpected: got imm=%h tag=%h, required no output", out_imm, out_tag);
            end else begin
                e = sb.pop_front();
                if (out_imm !== e.imm || out_tag !== e.tag)
                    $display("FAIL out_entry: got imm=%h tag=%h, required imm=%h tag=%h",
                             out_imm, out_tag, e.imm, e.tag);
                else begin
                    n_pass++;
                    if (verbose) $display("out imm=%h tag=%h", out_imm, out_tag);
                end
            end
        end
    end

    task automatic send(input logic [31:0] inst, input logic [2:0] t, input logic [31:0] tag,
                        input logic [31:0] exp);
        item_t it;
        int    k;
        @(posedge clk); #1;
        in_valid = 1'b1; in_inst = inst; in_imm_type = t; in_tag = tag;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 100) begin @(negedge clk); k++; end
        n_checks++;
        if (!in_ready) begin
            $display("FAIL send_accept: got in_ready=%b, required 1 within 100 cycles", in_ready);
        end else begin
            n_pass++;
            it.imm = exp; it.tag = tag;
            sb.push_back(it);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 200) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        n_checks++;
        if (sb.size() != 0 || out_valid !== 1'b0)
            $display("FAIL drain: got pending=%0d out_valid=%b, required 0 and 0", sb.size(), out_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_imm_type = '0; in_tag = '0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0 || out_tag !== 32'h0)
            $display("FAIL reset_state: got v=%b r=%b imm=%h tag=%h, required 0 1 0 0",
                     out_valid, in_ready, out_imm, out_tag);
        else n_pass++;
        n_checks++;
        if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || out_imm64 !== 64'h0)
            $display("FAIL reset_state64: got v=%b r=%b imm=%h, required 0 1 0",
                     out_valid64, in_ready64, out_imm64);
        else n_pass++;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_release: got v=%b r=%b, required 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_directed32();
        out_ready = 1'b1;
        send(32'hFFF00093, 3'd1, 32'h100, 32'hFFFFFFFF);
        send(32'hFE112E23, 3'd2, 32'h101, 32'hFFFFFFFC);
        send(32'hFE000CE3, 3'd3, 32'h102, 32'hFFFFFFF8);
        send(32'h0010006F, 3'd5, 32'h103, 32'h00000800);
        send(32'h123450B7, 3'd4, 32'h104, 32'h12345000);
        send(32'h00000033, 3'd0, 32'h105, 32'h00000000);
        send(32'h03F0D093, 3'd7, 32'h106, 32'h0000001F);
        idle();
        drain();
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_a;
        item_t       it;
        int          k;
        exp_a = ref_imm(32'hABC00013, 3'd1, 32)[31:0];
        out_ready = 1'b0;
        send(32'hABC00013, 3'd1, 32'h200, exp_a);
        send(32'h8000A023, 3'd2, 32'h201, ref_imm(32'h8000A023, 3'd2, 32)[31:0]);
        @(posedge clk); #1;
        in_valid = 1'b1; in_inst = 32'h7FF0006F; in_imm_type = 3'd5; in_tag = 32'h202;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL bp_full: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_imm !== exp_a || out_tag !== 32'h200 || in_ready !== 1'b0)
                $display("FAIL bp_hold: got imm=%h tag=%h r=%b, required %h 00000200 0",
                         out_imm, out_tag, in_ready, exp_a);
            else n_pass++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 100) begin @(negedge clk); k++; end
        n_checks++;
        if (!in_ready) $display("FAIL bp_resume: got in_ready=%b, required 1", in_ready);
        else begin
            n_pass++;
            it.imm = ref_imm(32'h7FF0006F, 3'd5, 32)[31:0]; it.tag = 32'h202;
            sb.push_back(it);
        end
        idle();
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(32'h00100093, 3'd1, 32'h300, ref_imm(32'h00100093, 3'd1, 32)[31:0]);
        send(32'hFFF0A023, 3'd2, 32'h301, ref_imm(32'hFFF0A023, 3'd2, 32)[31:0]);
        @(posedge clk); #1;
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h12345037; in_imm_type = 3'd4; in_tag = 32'h3FF;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_state: got v=%b r=%b, required 0 1", out_valid, in_ready);
        else n_pass++;
        repeat (3) @(negedge clk);
        send(32'h000F8073, 3'd6, 32'h302, 32'h0000001F);
        idle();
        drain();
    endtask

    task automatic test_async_reset();
        logic [31:0] exp_f;
        exp_f = ref_imm(32'h0FF00513, 3'd1, 32)[31:0];
        out_ready = 1'b0;
        send(32'h00500093, 3'd1, 32'h400, ref_imm(32'h00500093, 3'd1, 32)[31:0]);
        send(32'h00600093, 3'd1, 32'h401, ref_imm(32'h00600093, 3'd1, 32)[31:0]);
        idle();
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0)
            $display("FAIL async_reset: got v=%b r=%b imm=%h, required 0 1 0", out_valid, in_ready, out_imm);
        else n_pass++;
        sb.delete();
        @(negedge clk); rstn = 1'b1;
        out_ready = 1'b1;
        send(32'h0FF00513, 3'd1, 32'h402, exp_f);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_imm !== exp_f)
            $display("FAIL post_reset_latency: got v=%b imm=%h, required 1 %h", out_valid, out_imm, exp_f);
        else n_pass++;
        drain();
    endtask

    task automatic test_xlen64();
        logic [31:0] ins [4];
        logic [2:0]  typ [4];
        logic [63:0] exp [4];
        ins = '{32'h80000037, 32'h03F0D093, 32'h000F8073, 32'h00000033};
        typ = '{3'd4, 3'd7, 3'd6, 3'd0};
        exp = '{64'hFFFFFFFF80000000, 64'h3F, 64'h1F, 64'h0};
        out_ready64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b1; in_inst64 = ins[0]; in_imm_type64 = typ[0]; in_tag64 = 32'h500;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid64 !== 1'b1 || out_imm64 !== exp[k] || out_tag64 !== 32'h500 + k)
                $display("FAIL x64_entry%0d: got v=%b imm=%h tag=%h, required 1 %h %h",
                         k, out_valid64, out_imm64, out_tag64, exp[k], 32'h500 + k);
            else begin
                n_pass++;
                if (verbose) $display("out64 imm=%h tag=%h", out_imm64, out_tag64);
            end
            if (k < 3) begin
                in_inst64 = ins[k+1]; in_imm_type64 = typ[k+1]; in_tag64 = 32'h500 + k + 1;
            end else in_valid64 = 1'b0;
        end
    endtask

    task automatic test_random();
        item_t it;
        bit    pending;
        pending = 1'b0;
        verbose = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            if (!pending) begin
                in_valid    = ($urandom_range(0, 3) != 0);
                in_inst     = $urandom;
                in_imm_type = 3'($urandom_range(0, 7));
                in_tag      = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                it.imm = ref_imm(in_inst, in_imm_type, 32)[31:0]; it.tag = in_tag;
                sb.push_back(it);
                pending = 1'b0;
            end else pending = in_valid;
        end
        idle();
        drain();
        verbose = 1'b1;
    endtask

    initial begin
        flush64 = 1'b0; in_valid64 = 1'b0; out_ready64 = 1'b0;
        in_inst64 = '0; in_imm_type64 = '0; in_tag64 = '0;
        test_reset();
        test_directed32();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_xlen64();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
